id_stream: RTL and testbench

Parametrised streaming Y86 decode stage for the pipelined core. It accepts raw instruction bytes from fetch in fixed-width beats and buffers them in a circular byte queue. It splits the stream into variable-length instructions and emits one registered, fully decoded instruction per cycle over a valid/ready handshake to the execute side. It handles PC redirects and halt, and flags invalid opcodes instead of silently treating them as NOP.

---
 rtl/y86_pkg.sv | 44 ++++
 rtl/id_byte_queue.sv | 66 ++++++
 rtl/id_stream.sv | 195 +++++++++++++++++++
 tb/tb_id_stream.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 decode definitions: opcodes, register sentinel,
// decode state and instruction length lookup.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } dec_state_t;

    // Unknown opcodes are one byte long so decode can step past them.
    function automatic int unsigned inst_len(
        input logic [3:0]  icode,
        input int unsigned word_bytes
    );
        case (icode)
            I_HALT, I_NOP, I_RET:
                return 1;
            I_CMOVXX, I_OPL, I_PUSHL, I_POPL:
                return 2;
            I_IRMOVL, I_RMMOVL, I_MRMOVL:
                return 2 + word_bytes;
            I_JXX, I_CALL:
                return 1 + word_bytes;
            default:
                return 1;
        endcase
    endfunction

endpackage

// File: rtl/id_byte_queue.sv
// Circular byte queue: fixed-width beat push, variable-length pop,
// and a peek window of the bytes at the head.
module id_byte_queue
    import y86_pkg::*;
#(
    parameter  int FETCH_BYTES = 4,
    parameter  int BUF_BYTES   = 16,
    parameter  int PEEK_BYTES  = 6,
    localparam int AW = $clog2(BUF_BYTES),
    localparam int CW = $clog2(BUF_BYTES + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [8*FETCH_BYTES-1:0] i_push_data,
    input  logic                     i_pop,
    input  logic [CW-1:0]            i_pop_len,
    output logic [CW-1:0]            o_count,
    output logic [8*PEEK_BYTES-1:0]  o_peek
);

    logic [7:0]    r_mem [BUF_BYTES];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_push_n;
    logic [CW-1:0] w_pop_n;

    assign w_push_n = i_push ? CW'(FETCH_BYTES) : '0;
    assign w_pop_n  = i_pop  ? i_pop_len        : '0;

    always_ff @(posedge clk) begin
        if (i_push) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                r_mem[r_wr + AW'(k)] <= i_push_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wr <= r_wr + AW'(FETCH_BYTES);
            end
            if (i_pop) begin
                r_rd <= r_rd + AW'(i_pop_len);
            end
            r_count <= r_count + w_push_n - w_pop_n;
        end
    end

    always_comb begin
        o_peek = '0;
        for (int k = 0; k < PEEK_BYTES; k++) begin
            o_peek[8*k +: 8] = r_mem[r_rd + AW'(k)];
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/id_stream.sv
// Streaming Y86 decode stage: splits buffered fetch bytes into
// instructions and registers one decoded instruction per cycle.
module id_stream
    import y86_pkg::*;
#(
    parameter int WORD_BYTES  = 4,
    parameter int PC_W        = 16,
    parameter int FETCH_BYTES = 4,
    parameter int BUF_BYTES   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [PC_W-1:0]          redirect_pc,
    input  logic                     fetch_valid,
    output logic                     fetch_ready,
    input  logic [8*FETCH_BYTES-1:0] fetch_data,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [PC_W-1:0]          pc_o,
    output logic [3:0]               icode_o,
    output logic [3:0]               ifun_o,
    output logic [3:0]               rA_o,
    output logic [3:0]               rB_o,
    output logic [8*WORD_BYTES-1:0]  valC_o,
    output logic [PC_W-1:0]          valP_o,
    output logic                     err_o,
    output logic                     halted_o
);

    localparam int PEEK = 2 + WORD_BYTES;
    localparam int CW   = $clog2(BUF_BYTES + 1);
    localparam int VW   = 8 * WORD_BYTES;

    dec_state_t r_state;
    dec_state_t w_state_nxt;

    logic [PC_W-1:0]   r_pc;
    logic              r_valid;
    logic [PC_W-1:0]   r_pc_o;
    logic [3:0]        r_icode;
    logic [3:0]        r_ifun;
    logic [3:0]        r_ra;
    logic [3:0]        r_rb;
    logic [VW-1:0]     r_valc;
    logic [PC_W-1:0]   r_valp;
    logic              r_err;

    logic [CW-1:0]     w_count;
    logic [8*PEEK-1:0] w_peek;
    logic [3:0]        w_icode;
    logic [3:0]        w_ifun;
    logic [CW-1:0]     w_len;
    logic              w_push;
    logic              w_fire;
    logic              w_has_reg;
    logic              w_has_cst;
    logic              w_err;
    logic [3:0]        w_ra;
    logic [3:0]        w_rb;
    logic [VW-1:0]     w_valc;
    logic [PC_W-1:0]   w_valp;

    assign fetch_ready = (w_count <= CW'(BUF_BYTES - FETCH_BYTES))
                       & ~redirect_valid & ~rst;
    assign w_push = fetch_valid & fetch_ready;

    id_byte_queue #(
        .FETCH_BYTES(FETCH_BYTES),
        .BUF_BYTES  (BUF_BYTES),
        .PEEK_BYTES (PEEK)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (redirect_valid),
        .i_push     (w_push),
        .i_push_data(fetch_data),
        .i_pop      (w_fire),
        .i_pop_len  (w_len),
        .o_count    (w_count),
        .o_peek     (w_peek)
    );

    assign w_icode = w_peek[7:4];
    assign w_ifun  = w_peek[3:0];
    assign w_len   = CW'(inst_len(w_icode, WORD_BYTES));
    assign w_valp  = r_pc + PC_W'(w_len);

    assign w_fire = (r_state == ST_RUN)
                  & (w_count >= w_len)
                  & (~r_valid | dec_ready)
                  & ~redirect_valid & ~rst;

    always_comb begin
        w_has_reg = 1'b0;
        w_has_cst = 1'b0;
        w_err     = 1'b0;
        unique case (w_icode)
            I_HALT, I_NOP, I_RET: ;
            I_CMOVXX, I_OPL, I_PUSHL, I_POPL:
                w_has_reg = 1'b1;
            I_IRMOVL, I_RMMOVL, I_MRMOVL: begin
                w_has_reg = 1'b1;
                w_has_cst = 1'b1;
            end
            I_JXX, I_CALL:
                w_has_cst = 1'b1;
            default:
                w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_ra   = REG_NONE;
        w_rb   = REG_NONE;
        w_valc = '0;
        if (w_has_reg) begin
            w_ra = w_peek[15:12];
            w_rb = w_peek[11:8];
        end
        // Constant follows the register byte when there is one.
        if (w_has_cst) begin
            for (int j = 0; j < WORD_BYTES; j++) begin
                w_valc[8*j +: 8] = w_has_reg ?
                    w_peek[8*(j+2) +: 8] :
                    w_peek[8*(j+1) +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = ST_RUN;
        end else if (w_fire && w_icode == I_HALT) begin
            w_state_nxt = ST_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_fire) begin
            r_pc <= w_valp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_valid <= 1'b0;
            r_pc_o  <= '0;
            r_icode <= '0;
            r_ifun  <= '0;
            r_ra    <= REG_NONE;
            r_rb    <= REG_NONE;
            r_valc  <= '0;
            r_valp  <= '0;
            r_err   <= 1'b0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_pc_o  <= r_pc;
            r_icode <= w_icode;
            r_ifun  <= w_ifun;
            r_ra    <= w_ra;
            r_rb    <= w_rb;
            r_valc  <= w_valc;
            r_valp  <= w_valp;
            r_err   <= w_err;
        end else if (dec_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign dec_valid = r_valid;
    assign pc_o      = r_pc_o;
    assign icode_o   = r_icode;
    assign ifun_o    = r_ifun;
    assign rA_o      = r_ra;
    assign rB_o      = r_rb;
    assign valC_o    = r_valc;
    assign valP_o    = r_valp;
    assign err_o     = r_err;
    assign halted_o  = (r_state == ST_HALT);

endmodule

// File: tb/tb_id_stream.sv
// Directed bench for id_stream: decoded instructions are captured on
// handshakes and compared against hand-computed expectations.
module tb_id_stream;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] pc_o;
    logic [3:0]  icode_o;
    logic [3:0]  ifun_o;
    logic [3:0]  rA_o;
    logic [3:0]  rB_o;
    logic [31:0] valC_o;
    logic [15:0] valP_o;
    logic        err_o;
    logic        halted_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] pc;
        logic [3:0]  ic;
        logic [3:0]  fn;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] vc;
        logic [15:0] vp;
        logic        err;
    } rec_t;

    rec_t cap[$];

    id_stream #(
        .WORD_BYTES (4),
        .PC_W       (16),
        .FETCH_BYTES(4),
        .BUF_BYTES  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_valid   (fetch_valid),
        .fetch_ready   (fetch_ready),
        .fetch_data    (fetch_data),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .pc_o          (pc_o),
        .icode_o       (icode_o),
        .ifun_o        (ifun_o),
        .rA_o          (rA_o),
        .rB_o          (rB_o),
        .valC_o        (valC_o),
        .valP_o        (valP_o),
        .err_o         (err_o),
        .halted_o      (halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && !redirect_valid && dec_valid && dec_ready) begin
            cap.push_back('{pc_o, icode_o, ifun_o, rA_o, rB_o,
                            valC_o, valP_o, err_o});
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic exp_inst(input string tag, input int idx,
                            input logic [15:0] pc,
                            input logic [3:0] ic, input logic [3:0] fn,
                            input logic [3:0] ra, input logic [3:0] rb,
                            input logic [31:0] vc,
                            input logic [15:0] vp,
                            input logic err);
        if (idx >= cap.size()) begin
            check({tag, ".missing"}, 64'(cap.size()), 64'(idx + 1));
        end else begin
            check({tag, ".pc"},  cap[idx].pc,  pc);
            check({tag, ".ic"},  cap[idx].ic,  ic);
            check({tag, ".fn"},  cap[idx].fn,  fn);
            check({tag, ".ra"},  cap[idx].ra,  ra);
            check({tag, ".rb"},  cap[idx].rb,  rb);
            check({tag, ".vc"},  cap[idx].vc,  vc);
            check({tag, ".vp"},  cap[idx].vp,  vp);
            check({tag, ".err"}, cap[idx].err, err);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [31:0] d);
        int n;
        n = 0;
        fetch_valid = 1'b1;
        fetch_data  = d;
        @(negedge clk);
        while (!fetch_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("fetch_timeout", 64'(n), 0);
        @(posedge clk);
        #1;
        fetch_valid = 1'b0;
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, ".valid"},  dec_valid, 0);
        check({tag, ".halted"}, halted_o,  0);
        check({tag, ".fready"}, fetch_ready, 0);
        check({tag, ".pc"},     pc_o,    0);
        check({tag, ".ic"},     icode_o, 0);
        check({tag, ".fn"},     ifun_o,  0);
        check({tag, ".ra"},     rA_o,    4'hF);
        check({tag, ".rb"},     rB_o,    4'hF);
        check({tag, ".vc"},     valC_o,  0);
        check({tag, ".vp"},     valP_o,  0);
        check({tag, ".err"},    err_o,   0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [80:0] snap;
        logic        have_snap;
        int          accepted;
        int          unstable;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fetch_valid    = 1'b0;
        fetch_data     = '0;
        dec_ready      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst.fready_after", fetch_ready, 1);
        tick();

        // nop, irmovl $0x12345678,%edx, halt
        dec_ready = 1'b1;
        cap.delete();
        send(32'h78F2_3010);
        send(32'h0012_3456);
        idle(8);
        check("t1.count", 64'(cap.size()), 3);
        exp_inst("t1.nop", 0, 16'h0000, 4'h1, 4'h0, 4'hF, 4'hF,
                 32'h0, 16'h0001, 1'b0);
        exp_inst("t1.irm", 1, 16'h0001, 4'h3, 4'h0, 4'hF, 4'h2,
                 32'h1234_5678, 16'h0007, 1'b0);
        exp_inst("t1.halt", 2, 16'h0007, 4'h0, 4'h0, 4'hF, 4'hF,
                 32'h0, 16'h0008, 1'b0);
        check("t1.halted", halted_o, 1);
        send(32'h1010_1010);
        idle(5);
        check("t1.no_more", 64'(cap.size()), 3);
        check("t1.valid_low", dec_valid, 0);
        check("t1.still_halted", halted_o, 1);

        // irmovl split across two beats
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        check("t2.unhalted", halted_o, 0);
        cap.delete();
        send(32'h5634_F330);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2.wait%0d", i), dec_valid, 0);
            tick();
        end
        send(32'h1010_9A78);
        idle(5);
        check("t2.count", 64'(cap.size()), 3);
        exp_inst("t2.irm", 0, 16'h0100, 4'h3, 4'h0, 4'hF, 4'h3,
                 32'h9A78_5634, 16'h0106, 1'b0);
        exp_inst("t2.nop0", 1, 16'h0106, 4'h1, 4'h0, 4'hF, 4'hF,
                 32'h0, 16'h0107, 1'b0);
        exp_inst("t2.nop1", 2, 16'h0107, 4'h1, 4'h0, 4'hF, 4'hF,
                 32'h0, 16'h0108, 1'b0);

        // Stall with fetch running, across pointer wrap
        dec_ready   = 1'b0;
        cap.delete();
        fetch_valid = 1'b1;
        fetch_data  = 32'h2361_0160;
        accepted    = 0;
        unstable    = 0;
        have_snap   = 1'b0;
        snap        = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fetch_valid && fetch_ready) accepted++;
            if (dec_valid) begin
                if (!have_snap) begin
                    snap = {pc_o, icode_o, ifun_o, rA_o, rB_o,
                            valC_o, valP_o, err_o};
                    have_snap = 1'b1;
                end else if (snap !== {pc_o, icode_o, ifun_o, rA_o,
                                       rB_o, valC_o, valP_o, err_o}) begin
                    unstable++;
                end
            end
            @(posedge clk);
            #1;
        end
        fetch_valid = 1'b0;
        check("t3.accepted", 64'(accepted), 4);
        check("t3.fready_low", fetch_ready, 0);
        check("t3.unstable", 64'(unstable), 0);
        check("t3.held_valid", dec_valid, 1);
        check("t3.held_pc", pc_o, 16'h0108);
        check("t3.held_rb", rB_o, 4'h1);
        check("t3.held_vp", valP_o, 16'h010A);
        dec_ready = 1'b1;
        idle(12);
        check("t3.count", 64'(cap.size()), 8);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] pc;
            pc = 16'h0108 + 16'(2 * i);
            exp_inst($sformatf("t3.op%0d", i), i, pc, 4'h6,
                     4'(i % 2),
                     (i % 2) ? 4'h2 : 4'h0,
                     (i % 2) ? 4'h3 : 4'h1,
                     32'h0, pc + 16'h2, 1'b0);
        end

        // Invalid opcode 0xC0 followed by normal decode
        cap.delete();
        send(32'h4561_10C0);
        idle(5);
        check("t4.count", 64'(cap.size()), 3);
        exp_inst("t4.bad", 0, 16'h0118, 4'hC, 4'h0, 4'hF, 4'hF,
                 32'h0, 16'h0119, 1'b1);
        exp_inst("t4.nop", 1, 16'h0119, 4'h1, 4'h0, 4'hF, 4'hF,
                 32'h0, 16'h011A, 1'b0);
        exp_inst("t4.op", 2, 16'h011A, 4'h6, 4'h1, 4'h4, 4'h5,
                 32'h0, 16'h011C, 1'b0);
        check("t4.not_halted", halted_o, 0);

        // Redirect with same-cycle beat and handshake
        dec_ready = 1'b0;
        send(32'h1010_1010);
        idle(2);
        check("t5.pre_valid", dec_valid, 1);
        check("t5.pre_pc", pc_o, 16'h011C);
        cap.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        fetch_valid    = 1'b1;
        fetch_data     = 32'h1010_1010;
        dec_ready      = 1'b1;
        @(negedge clk);
        check("t5.fready_redir", fetch_ready, 0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        fetch_valid    = 1'b0;
        dec_ready      = 1'b0;
        check("t5.valid0", dec_valid, 0);
        tick();
        check("t5.empty", dec_valid, 0);
        check("t5.no_cap", 64'(cap.size()), 0);
        dec_ready = 1'b1;
        send(32'h1010_1010);
        idle(6);
        check("t5.count", 64'(cap.size()), 4);
        exp_inst("t5.first", 0, 16'h0040, 4'h1, 4'h0, 4'hF, 4'hF,
                 32'h0, 16'h0041, 1'b0);
        exp_inst("t5.last", 3, 16'h0043, 4'h1, 4'h0, 4'hF, 4'hF,
                 32'h0, 16'h0044, 1'b0);

        // Reset mid-stream with a full queue
        dec_ready   = 1'b0;
        fetch_valid = 1'b1;
        fetch_data  = 32'h1010_1010;
        idle(8);
        check("t6.full", fetch_ready, 0);
        check("t6.pre_valid", dec_valid, 1);
        rst = 1'b1;
        tick();
        reset_outputs("t6.rst");
        rst         = 1'b0;
        fetch_valid = 1'b0;
        @(negedge clk);
        check("t6.fready", fetch_ready, 1);
        @(posedge clk);
        #1;
        cap.delete();
        dec_ready = 1'b1;
        send(32'h1010_1010);
        idle(6);
        check("t6.count", 64'(cap.size()), 4);
        exp_inst("t6.first", 0, 16'h0000, 4'h1, 4'h0, 4'hF, 4'hF,
                 32'h0, 16'h0001, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
